// File: rtl/lsu_pkg.sv
// Shared types, constants and helpers for the load/store bus front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, bus WLEN codes, RV32 funct3 codes,
// request record, load formatting and request classification helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  // Bus operation codes
  localparam logic [1:0] WLEN_RD32 = 2'b00;
  localparam logic [1:0] WLEN_WR8  = 2'b01;
  localparam logic [1:0] WLEN_WR16 = 2'b10;
  localparam logic [1:0] WLEN_WR32 = 2'b11;

  // RV32 funct3 codes (stores only use B/H/W)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Request as latched on accept
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Extract and extend load data from a 32-bit bus read. The bus reads the
  // halfword containing a byte, so byte lanes come from bits [15:0] only.
  function automatic logic [31:0] lsu_format_load(input logic [2:0]  funct3,
                                                  input logic        addr0,
                                                  input logic [31:0] rdata);
    logic [7:0] byte_sel;
    lsu_format_load = '0;
    byte_sel = addr0 ? rdata[15:8] : rdata[7:0];
    case (funct3)
      F3_B:    lsu_format_load = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   lsu_format_load = {24'h0, byte_sel};
      F3_H:    lsu_format_load = {{16{rdata[15]}}, rdata[15:0]};
      F3_HU:   lsu_format_load = {16'h0, rdata[15:0]};
      F3_W:    lsu_format_load = rdata;
      default: lsu_format_load = '0;
    endcase
  endfunction

  // True when the request must be rejected without touching the bus:
  // unknown funct3 for the direction, or an address not aligned to the size.
  function automatic logic lsu_req_bad(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    if (we) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      legal = (funct3 == F3_B)  || (funct3 == F3_H)  || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    // funct3[1:0] carries the size for all legal codes: 01 half, 10 word
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    lsu_req_bad = !legal || misaligned;
  endfunction

  // Bus operation for a legal request: every load is a full-word read.
  function automatic logic [1:0] lsu_wlen(input logic       we,
                                          input logic [2:0] funct3);
    lsu_wlen = WLEN_RD32;
    if (we) begin
      case (funct3[1:0])
        2'b00:   lsu_wlen = WLEN_WR8;
        2'b01:   lsu_wlen = WLEN_WR16;
        default: lsu_wlen = WLEN_WR32;
      endcase
    end
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction and sign/zero extension from a raw bus word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   funct3_i  load funct3 (LB/LH/LW/LBU/LHU)
//   addr0_i   byte address bit 0 (selects the byte lane within the halfword)
//   rdata_i   raw 32-bit bus read data
//   data_o    extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        addr0_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = lsu_format_load(funct3_i, addr0_i, rdata_i);
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Single-outstanding RV32 load/store front end driving the CPU memory bus.
// Latency: idle bus -> accept, 1 SYNC cycle, 1 ISSUE cycle, WAIT until READY, 1 RESP cycle; errors respond the cycle after accept.
// Backpressure: req_ready only in IDLE; bus READY gates SYNC and WAIT, bounded by TIMEOUT_CYC.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req_valid/req_ready          request handshake; req_we, req_funct3, req_addr, req_wdata payload
//   resp_valid                   one-cycle completion pulse; resp_err, resp_rdata qualify it
//   bus_address/bus_wdata/bus_wlen  bus command, stable from accept until the next accept
//   bus_en_n                     active-low strobe, low exactly during the ISSUE cycle
//   bus_ready/bus_rdata          bus idle/done and read data
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_wlen,
  output logic        bus_en_n,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  // Counter value on the last SYNC/WAIT cycle before giving up; the counter
  // starts at 0 on the accept edge, so the abort lands TIMEOUT_CYC edges later.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic [1:0]  wlen_q, wlen_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] load_data;

  lsu_load_align u_align (
    .funct3_i (req_q.funct3),
    .addr0_i  (req_q.addr[0]),
    .rdata_i  (bus_rdata),
    .data_o   (load_data)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wlen_d  = wlen_q;
    cnt_d   = cnt_q;
    armed_d = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d  = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
          wlen_d = lsu_wlen(req_we, req_funct3);
          cnt_d  = '0;
          if (lsu_req_bad(req_we, req_funct3, req_addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_SYNC;
          end
        end
      end

      // The bus may still be busy with an access started before our reset.
      ST_SYNC: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ready) begin
          state_d = ST_ISSUE;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
      end

      // READY is still high during the first WAIT cycle (the bus drops it on
      // the ISSUE edge), so only trust it once armed_q is set.
      ST_WAIT: begin
        cnt_d   = cnt_q + 8'd1;
        armed_d = 1'b1;
        if (armed_q && bus_ready) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = req_q.we ? 32'h0 : load_data;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
        rdata_d = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      wlen_q  <= WLEN_RD32;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wlen_q  <= wlen_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Everything below is a register or a pure state decode.
  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_err    = err_q;
  assign resp_rdata  = rdata_q;
  assign bus_en_n    = (state_q != ST_ISSUE);
  assign bus_wlen    = wlen_q;
  assign bus_address = req_q.addr;
  assign bus_wdata   = req_q.wdata;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master with a behavioural bus model.
// Latency: bus model raises READY 4 cycles after the ISSUE edge.
// Backpressure: bus model can be stalled (READY held low) to force timeouts.
module tb_lsu_bus_master;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] bus_address;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_wlen;
  logic        bus_en_n;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  logic        rdy_m;
  logic        bus_stall;
  logic [31:0] bus_next_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  typedef struct {
    logic [1:0]  wlen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  assign bus_ready = bus_stall ? 1'b0 : rdy_m;

  lsu_bus_master #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .bus_address (bus_address),
    .bus_wdata   (bus_wdata),
    .bus_wlen    (bus_wlen),
    .bus_en_n    (bus_en_n),
    .bus_ready   (bus_ready),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"},   32'(req_ready),  32'd1);
    chk({tag, "_bus_en_n"},    32'(bus_en_n),   32'd1);
    chk({tag, "_bus_wlen"},    32'(bus_wlen),   32'd0);
    chk({tag, "_bus_address"}, bus_address,     32'd0);
    chk({tag, "_bus_wdata"},   bus_wdata,       32'd0);
    chk({tag, "_resp_valid"},  32'(resp_valid), 32'd0);
    chk({tag, "_resp_err"},    32'(resp_err),   32'd0);
    chk({tag, "_resp_rdata"},  resp_rdata,      32'd0);
  endtask

  // Response monitor: pops one expectation per resp_valid pulse.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: err=%0b rdata=0x%08h with no request pending", resp_err, resp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_rdata", resp_rdata, e.rdata);
        if (e.lat >= 0) chk("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
      end
    end
  end

  // Bus model: checks each strobe against the expected command, drops READY
  // on the ISSUE edge and returns it with data 4 edges later.
  initial begin
    rdy_m = 1'b1;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reset_n && !bus_en_n) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: wlen=%0d addr=0x%08h", bus_wlen, bus_address);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("bus_wlen", 32'(bus_wlen), 32'(b.wlen));
          chk("bus_address", bus_address, b.addr);
          chk("bus_wdata", bus_wdata, b.wdata);
        end
        @(posedge clk);
        #1 rdy_m = 1'b0;
        @(negedge clk);
        chk("bus_en_n_one_cycle", 32'(bus_en_n), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        rdy_m = 1'b1;
        bus_rdata = bus_next_rdata;
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: %0d responses still pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd,
                        input logic bus_exp, input logic [1:0] wlen,
                        input logic err, input logic [31:0] rdata, input int lat,
                        input logic want_resp);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_req", 32'(req_ready), 32'd1);
    bus_next_rdata = rd;
    if (bus_exp) bus_q.push_back('{wlen: wlen, addr: addr, wdata: wdata});
    if (want_resp) exp_q.push_back('{err: err, rdata: rdata, lat: lat});
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc = cyc;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (want_resp) wait_drain();
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    bus_stall = 1'b0;
    bus_next_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("rst");
    @(negedge clk);
    reset_n = 1'b1;

    //     we f3   addr          wdata          bus rdata      bus wlen    err resp rdata     lat resp
    do_req(0, 3'd0, 32'h0000_0005, 32'h0,         32'h1234_80FF, 1, 2'b00, 0, 32'hFFFF_FF80, -1, 1); // LB
    do_req(0, 3'd4, 32'h0000_0005, 32'h0,         32'h1234_80FF, 1, 2'b00, 0, 32'h0000_0080, -1, 1); // LBU
    do_req(1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         1, 2'b11, 0, 32'h0,         -1, 1); // SW
    do_req(0, 3'd2, 32'h0000_0102, 32'h0,         32'h0,         0, 2'b00, 1, 32'h0,          0, 1); // LW misaligned
    do_req(0, 3'd1, 32'h0000_0006, 32'h0,         32'h0000_8001, 1, 2'b00, 0, 32'hFFFF_8001, -1, 1); // LH
    do_req(0, 3'd5, 32'h0000_0006, 32'h0,         32'h0000_8001, 1, 2'b00, 0, 32'h0000_8001, -1, 1); // LHU
    do_req(0, 3'd2, 32'h0000_0008, 32'h55AA_55AA, 32'hCAFE_F00D, 1, 2'b00, 0, 32'hCAFE_F00D, -1, 1); // LW
    do_req(1, 3'd0, 32'h0000_0007, 32'h0000_0011, 32'h0,         1, 2'b01, 0, 32'h0,         -1, 1); // SB
    do_req(1, 3'd1, 32'h0000_0002, 32'h0000_BEEF, 32'h0,         1, 2'b10, 0, 32'h0,         -1, 1); // SH
    do_req(0, 3'd0, 32'h0000_0004, 32'h0,         32'h0000_017F, 1, 2'b00, 0, 32'h0000_007F, -1, 1); // LB low lane
    do_req(0, 3'd3, 32'h0000_0000, 32'h0,         32'h0,         0, 2'b00, 1, 32'h0,          0, 1); // illegal load
    do_req(1, 3'd4, 32'h0000_0000, 32'h0,         32'h0,         0, 2'b00, 1, 32'h0,          0, 1); // illegal store
    do_req(1, 3'd1, 32'h0000_0003, 32'h0000_1234, 32'h0,         0, 2'b00, 1, 32'h0,          0, 1); // SH misaligned

    // Timeout: bus never ready, no strobe allowed
    bus_stall = 1'b1;
    do_req(1, 3'd1, 32'h0008_0004, 32'h0000_1234, 32'h0,         0, 2'b00, 1, 32'h0,         TO, 1);
    bus_stall = 1'b0;

    // Reset during WAIT of an LW: no response may follow
    do_req(0, 3'd2, 32'h0000_0010, 32'h0,         32'h8765_4321, 1, 2'b00, 0, 32'h0,         -1, 0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    do_req(0, 3'd5, 32'h0000_0002, 32'h0,         32'h0000_F00D, 1, 2'b00, 0, 32'h0000_F00D, -1, 1); // LHU after reset

    repeat (10) @(negedge clk);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/lsu_bus_master.md
# lsu_bus_master

Load/store front end that sits directly upstream of the CPU memory bus. It accepts one RV32 load or store per request. It checks alignment and funct3, then issues a single bus transaction (RD32, WR8, WR16 or WR32) with a one-cycle active-low enable. It waits for bus READY, then returns sign- or zero-extended load data, or an error, to the core through a valid/ready request and response pair.

## Interface
- `TIMEOUT_CYC`, default 64: cycles spent in SYNC plus WAIT before the access is aborted with an error.
- `clk` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset. This is the already-decided reset: one clock, asynchronous active-low reset.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: high only in IDLE; a request is accepted on the posedge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3. Loads use LB=0, LH=1, LW=2, LBU=4, LHU=5. Stores use SB=0, SH=1, SW=2.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `resp_valid` out 1: one-cycle pulse when the access completes.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: qualifies `resp_valid`; set on misalignment, illegal funct3 or timeout.
- `bus_address` out 32: bus address.
- `bus_wdata` out 32: bus write data.
- `bus_wlen` out 2: bus operation, RD32=00, WR8=01, WR16=10, WR32=11.
- `bus_en_n` out 1: active-low transaction strobe, low for exactly one cycle per access.
- `bus_ready` in 1: bus idle/done.
- `bus_rdata` in 32: bus read data, valid while `bus_ready`=1 after an RD32.

## Operation
- **States:** IDLE, SYNC, ISSUE, WAIT, RESP.
- **IDLE:**
  - On accept, latch `we`, `funct3`, `addr` and `wdata`.
  - If funct3 is illegal, or the access is misaligned (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0), go to RESP with err=1. No bus activity in this case.
  - Otherwise go to SYNC.
- **SYNC:** wait for `bus_ready`=1, which covers a bus still busy after our reset. Then go to ISSUE.
- **ISSUE:**
  - Exactly one cycle with `bus_en_n`=0.
  - `bus_wlen` is RD32 for every load, WR8 for SB, WR16 for SH, WR32 for SW.
  - `bus_address` is the latched addr. `bus_wdata` is the latched wdata.
  - Next state is WAIT.
- **WAIT:** on the first cycle with `bus_ready`=1, capture the formatted data and go to RESP. `bus_ready` is ignored in the first WAIT cycle, because the bus drops READY on the ISSUE edge.
- **Load formatting (from bus_rdata):**
  - Byte: select `addr[0] ? rdata[15:8] : rdata[7:0]`. The bus reads the halfword that contains the byte.
  - LB sign-extends bit 7. LBU zero-extends.
  - LH sign-extends rdata[15:0]. LHU zero-extends rdata[15:0].
  - LW passes rdata[31:0].
- **Timeout:** an 8-bit counter clears on entry to SYNC and increments in SYNC and WAIT. When it reaches `TIMEOUT_CYC`, go to RESP with err=1 and `resp_rdata`=0, and leave the bus alone.
- **RESP:** `resp_valid`=1 for one cycle, then IDLE.
- **Core side:** the core must not assume a new request is accepted until `req_ready`.

## Timing
- **Reset values:** state=IDLE, `bus_en_n`=1, `bus_wlen`=00, `bus_address`=0, `bus_wdata`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `req_ready`=1.
- **Outputs:** all registered or decoded from state only. There is no combinational path from `req_*` to `bus_*`.
- **Latency with the bus idle:**
  - Accept edge to ISSUE: 2 cycles (SYNC takes 1).
  - LW through the bus's two reads: `bus_ready` returns 4 cycles after the ISSUE edge.
  - `resp_valid` follows 1 cycle after `bus_ready` is seen.
- **Error turnaround:** a misaligned or illegal request reaches `resp_valid` one cycle after accept.
- **Reset mid-operation:**
  - Immediate return to IDLE with `bus_en_n`=1, even mid-ISSUE.
  - No response is emitted for the aborted request.
- **Request during SYNC to RESP:** `req_ready`=0, so the request is not accepted.

## Structure
- **Shared package, `lsu_pkg`:**
  - State encoding.
  - WLEN constants.
  - funct3 constants.
  - A `lsu_format_load(funct3, addr0, rdata)` function.
- **Sub-module:** `lsu_load_align`, combinational extraction and extension. It is reused by the future cached LSU.
- **Top-level contents:** FSM, timeout counter, request latch.

## Test plan
- **LB, sign-extended:** LB addr=0x0000_0005, bus returns rdata=0x1234_80FF. Required: `bus_wlen`=00, `bus_address`=0x5, `resp_rdata`=0xFFFF_FF80, err=0.
- **LBU, zero-extended:** LBU with the same stimulus. Required: `resp_rdata`=0x0000_0080.
- **SW:** SW addr=0x100, wdata=0xDEAD_BEEF. Required: one cycle of `bus_en_n`=0 with `bus_wlen`=11, `bus_wdata`=0xDEAD_BEEF; then `resp_valid`, err=0, rdata=0.
- **Misaligned LW:** LW addr=0x102. Required: `resp_valid` with err=1 one cycle after accept, and `bus_en_n` stays high throughout.
- **Timeout:** hold `bus_ready`=0 forever after SH addr=0x80004. Required: err=1 exactly `TIMEOUT_CYC` cycles after SYNC entry, and `bus_en_n` never low.
- **Reset mid-access:** assert `reset_n`=0 during WAIT of an LW. Required: outputs go to reset values asynchronously; a following LHU addr=0x2 with rdata=0x0000_F00D returns 0x0000_F00D.
